tx_ltssm: RTL and testbench

TX_LTSSM -- requirements
Module: tx_ltssm

---
 rtl/tx_ltssm.sv | 183 ++++++++++++++++++
 tb/tb_tx_ltssm.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_ltssm.sv
// Transmit-side LTSSM job engine: latches a substate job on start, streams TS1/TS2/IDLE
// ordered sets to the lanes until the exit condition and post-count are met, then pulses finish.
module tx_ltssm (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic [3:0]    substate,
    input  logic [7:0]    linkNumber,
    input  logic [7:0]    rateId,
    input  logic          upConfigureCapability,
    input  logic [4:0]    numberOfDetectedLanes,
    input  logic          rxDone,
    input  logic          osReady,
    output logic [2047:0] orderedSets,
    output logic [15:0]   laneEnable,
    output logic          osValid,
    output logic          busy,
    output logic          finish
);

    typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_POST, ST_DONE} state_t;
    typedef enum logic [1:0] {OS_TS1, OS_TS2, OS_IDLE} osType_t;

    state_t          state_q;
    logic [10:0]     sentCnt_q;
    logic [10:0]     sentCnt_d;
    logic [4:0]      postCnt_q;
    logic [10:0]     minSent_q;
    logic [4:0]      post_q;
    logic            rxDoneSeen_q;
    logic [2047:0]   orderedSets_q;
    logic [15:0]     laneEnable_q;
    logic            osValid_q;
    logic            busy_q;
    logic            finish_q;

    logic            decSupported;
    osType_t         decType;
    logic [10:0]     decMinSent;
    logic [4:0]      decPost;
    logic [2047:0]   osWords_d;
    logic [15:0]     laneMask_d;
    logic [7:0]      fillSym;
    logic            rxDoneAny;
    logic            unusedRateBit;

    // Bit 6 of rateId is replaced by the up-configure capability in symbol 4.
    assign unusedRateBit = rateId[6];

    always_comb begin
        decSupported = 1'b1;
        decType      = OS_TS1;
        decMinSent   = 11'd1;
        decPost      = 5'd0;
        case (substate)
            4'd2:                     decMinSent = 11'd1024;
            4'd3, 4'd8, 4'd12: begin
                decType = OS_TS2;
                decPost = 5'd16;
            end
            4'd4, 4'd5, 4'd6, 4'd7, 4'd11: ;
            4'd9, 4'd13: begin
                decType = OS_IDLE;
                decPost = 5'd16;
            end
            default:                  decSupported = 1'b0;
        endcase
    end

    // Per-lane ordered-set images are built from the live inputs and captured on accept.
    always_comb begin
        osWords_d  = '0;
        laneMask_d = '0;
        fillSym    = (decType == OS_TS2) ? 8'h45 : 8'h4A;
        for (int i = 0; i < 16; i++) begin
            laneMask_d[i] = (5'(i) < numberOfDetectedLanes);
            if (laneMask_d[i] && (decType != OS_IDLE)) begin
                osWords_d[i*128 +: 8]      = 8'hBC;
                osWords_d[i*128 + 8 +: 8]  = linkNumber;
                osWords_d[i*128 + 16 +: 8] = 8'(i);
                osWords_d[i*128 + 32 +: 8] = {rateId[7], upConfigureCapability, rateId[5:0]};
                for (int k = 6; k < 16; k++) begin
                    osWords_d[i*128 + 8*k +: 8] = fillSym;
                end
            end
        end
    end

    always_comb begin
        sentCnt_d = sentCnt_q;
        if (osReady && (sentCnt_q != 11'h7FF)) begin
            sentCnt_d = sentCnt_q + 11'd1;
        end
    end

    assign rxDoneAny = rxDoneSeen_q | rxDone;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            sentCnt_q     <= '0;
            postCnt_q     <= '0;
            minSent_q     <= '0;
            post_q        <= '0;
            rxDoneSeen_q  <= 1'b0;
            orderedSets_q <= '0;
            laneEnable_q  <= '0;
            osValid_q     <= 1'b0;
            busy_q        <= 1'b0;
            finish_q      <= 1'b0;
        end else if (abort) begin
            state_q      <= ST_IDLE;
            sentCnt_q    <= '0;
            postCnt_q    <= '0;
            rxDoneSeen_q <= 1'b0;
            osValid_q    <= 1'b0;
            busy_q       <= 1'b0;
            finish_q     <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    finish_q <= 1'b0;
                    if (start) begin
                        sentCnt_q    <= '0;
                        postCnt_q    <= '0;
                        rxDoneSeen_q <= 1'b0;
                        minSent_q    <= decMinSent;
                        post_q       <= decPost;
                        busy_q       <= 1'b1;
                        if (decSupported) begin
                            state_q       <= ST_SEND;
                            osValid_q     <= 1'b1;
                            orderedSets_q <= osWords_d;
                            laneEnable_q  <= laneMask_d;
                        end else begin
                            state_q  <= ST_DONE;
                            finish_q <= 1'b1;
                        end
                    end
                end
                ST_SEND: begin
                    sentCnt_q    <= sentCnt_d;
                    rxDoneSeen_q <= rxDoneAny;
                    if ((sentCnt_d >= minSent_q) && rxDoneAny) begin
                        if (post_q != 5'd0) begin
                            state_q <= ST_POST;
                        end else begin
                            state_q   <= ST_DONE;
                            osValid_q <= 1'b0;
                            finish_q  <= 1'b1;
                        end
                    end
                end
                ST_POST: begin
                    if (osReady) begin
                        postCnt_q <= postCnt_q + 5'd1;
                        if ((postCnt_q + 5'd1) == post_q) begin
                            state_q   <= ST_DONE;
                            osValid_q <= 1'b0;
                            finish_q  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    finish_q     <= 1'b0;
                    busy_q       <= 1'b0;
                    sentCnt_q    <= '0;
                    postCnt_q    <= '0;
                    rxDoneSeen_q <= 1'b0;
                end
            endcase
        end
    end

    assign orderedSets = orderedSets_q;
    assign laneEnable  = laneEnable_q;
    assign osValid     = osValid_q;
    assign busy        = busy_q;
    assign finish      = finish_q;

endmodule

// File: tb/tb_tx_ltssm.sv
// Directed self-checking bench for tx_ltssm: job lengths, lane images, stalls, abort and reset.
module tb_tx_ltssm;

    logic          clk;
    logic          reset;
    logic          start;
    logic          abort;
    logic [3:0]    substate;
    logic [7:0]    linkNumber;
    logic [7:0]    rateId;
    logic          upConfigureCapability;
    logic [4:0]    numberOfDetectedLanes;
    logic          rxDone;
    logic          osReady;
    logic [2047:0] orderedSets;
    logic [15:0]   laneEnable;
    logic          osValid;
    logic          busy;
    logic          finish;

    int testsRun;
    int testsFailed;
    int xferTotal;
    int finishTotal;
    int stallTotal;
    int validTotal;
    int stableErr;
    logic          lastEdgeXfer;
    logic          prevStall;
    logic [2047:0] savedOS;

    tx_ltssm dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort), .substate(substate),
        .linkNumber(linkNumber), .rateId(rateId), .upConfigureCapability(upConfigureCapability),
        .numberOfDetectedLanes(numberOfDetectedLanes), .rxDone(rxDone), .osReady(osReady),
        .orderedSets(orderedSets), .laneEnable(laneEnable), .osValid(osValid),
        .busy(busy), .finish(finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge monitor: transfer/finish/stall counts and hold-stability of orderedSets.
    initial begin
        xferTotal = 0; finishTotal = 0; stallTotal = 0; validTotal = 0; stableErr = 0;
        lastEdgeXfer = 1'b0; prevStall = 1'b0; savedOS = '0;
    end
    always @(posedge clk) begin
        lastEdgeXfer = osValid && osReady;
        if (lastEdgeXfer) xferTotal++;
        if (finish) finishTotal++;
        if (osValid) validTotal++;
        if (osValid && !osReady) stallTotal++;
        if (prevStall && (orderedSets != savedOS)) stableErr++;
        prevStall = osValid && !osReady;
        savedOS   = orderedSets;
    end

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sub, input logic [7:0] link, input logic [7:0] rate,
                                 input logic upc, input logic [4:0] lanes);
        @(negedge clk);
        substate = sub; linkNumber = link; rateId = rate;
        upConfigureCapability = upc; numberOfDetectedLanes = lanes;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic waitFinish(input string tag, input int budget, input logic expectXferEdge);
        bit seen;
        seen = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (finish) begin
                seen = 1;
                break;
            end
        end
        checkOutput({tag, "_finishSeen"}, 128'(seen), 128'd1);
        if (seen) begin
            checkOutput({tag, "_finishAfterXfer"}, 128'(lastEdgeXfer), 128'(expectXferEdge));
            @(negedge clk);
            checkOutput({tag, "_finishOneCycle"}, 128'(finish), 128'd0);
            checkOutput({tag, "_idleBusy"}, 128'(busy), 128'd0);
        end
    endtask

    initial begin
        int base;
        int fbase;
        int vbase;
        bit hit;
        testsRun = 0; testsFailed = 0;
        reset = 1'b0; start = 1'b0; abort = 1'b0; substate = '0; linkNumber = '0; rateId = '0;
        upConfigureCapability = 1'b0; numberOfDetectedLanes = '0; rxDone = 1'b0; osReady = 1'b0;

        // Reset state
        #23;
        checkOutput("rst_osValid", 128'(osValid), 128'd0);
        checkOutput("rst_busy", 128'(busy), 128'd0);
        checkOutput("rst_finish", 128'(finish), 128'd0);
        checkOutput("rst_laneEnable", 128'(laneEnable), 128'd0);
        checkOutput("rst_osAny", 128'(|orderedSets), 128'd0);
        @(negedge clk);
        reset = 1'b1;

        // PollingActive: 1024 TS1 transfers on 4 lanes
        osReady = 1'b1; rxDone = 1'b1;
        base = xferTotal;
        applyStimulus(4'd2, 8'h11, 8'h00, 1'b0, 5'd4);
        checkOutput("t29_laneEnable", 128'(laneEnable), 128'h000F);
        checkOutput("t29_lane0", orderedSets[127:0], 128'h4A4A4A4A4A4A4A4A4A4A0000000011BC);
        checkOutput("t29_lane3", orderedSets[3*128 +: 128], 128'h4A4A4A4A4A4A4A4A4A4A0000000311BC);
        checkOutput("t29_lane4", orderedSets[4*128 +: 128], 128'd0);
        waitFinish("t29", 1200, 1'b1);
        checkOutput("t29_xfers", 128'(xferTotal - base), 128'd1024);

        // PollingConfig: rxDone with 5th transfer -> 5 + 16
        rxDone = 1'b0;
        base = xferTotal;
        applyStimulus(4'd3, 8'h3C, 8'hA5, 1'b1, 5'd1);
        checkOutput("t30_lane0", orderedSets[127:0], 128'h4545454545454545454500E500003CBC);
        checkOutput("t30_lane1", orderedSets[255:128], 128'd0);
        checkOutput("t30_laneEnable", 128'(laneEnable), 128'h0001);
        hit = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((xferTotal - base) == 4) begin
                rxDone = 1'b1;
                @(negedge clk);
                rxDone = 1'b0;
                hit = 1;
                break;
            end
        end
        checkOutput("t30_rxPulse", 128'(hit), 128'd1);
        waitFinish("t30", 100, 1'b1);
        checkOutput("t30_xfers", 128'(xferTotal - base), 128'd21);

        // Config.LinkWidth: lane image on 2 lanes, stalled first
        osReady = 1'b0; rxDone = 1'b1;
        base = xferTotal;
        applyStimulus(4'd4, 8'h07, 8'h7F, 1'b0, 5'd2);
        @(negedge clk);
        checkOutput("t31_laneEnable", 128'(laneEnable), 128'h0003);
        checkOutput("t31_lane1", orderedSets[255:128], 128'h4A4A4A4A4A4A4A4A4A4A003F000107BC);
        checkOutput("t31_lane2", orderedSets[383:256], 128'd0);
        checkOutput("t31_lane15", orderedSets[2047:1920], 128'd0);
        checkOutput("t31_validStall", 128'(osValid), 128'd1);
        osReady = 1'b1;
        waitFinish("t31", 20, 1'b1);
        checkOutput("t31_xfers", 128'(xferTotal - base), 128'd1);

        // ConfigComplete with random back-pressure: 1 + 16 transfers
        base = xferTotal;
        stableErr = 0;
        applyStimulus(4'd8, 8'h22, 8'h01, 1'b0, 5'd16);
        hit = 0;
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            if (finish) begin
                hit = 1;
                break;
            end
            osReady = 1'($urandom_range(0, 1));
        end
        checkOutput("t32_finishSeen", 128'(hit), 128'd1);
        checkOutput("t32_xfers", 128'(xferTotal - base), 128'd17);
        checkOutput("t32_stable", 128'(stableErr), 128'd0);
        checkOutput("t32_stalled", 128'(stallTotal > 0), 128'd1);
        @(negedge clk);

        // RecoveryRcvrCfg aborted mid-POST, then a fresh job
        osReady = 1'b1; rxDone = 1'b1;
        base = xferTotal;
        fbase = finishTotal;
        applyStimulus(4'd12, 8'h05, 8'h00, 1'b0, 5'd4);
        hit = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if ((xferTotal - base) == 5) begin
                hit = 1;
                break;
            end
        end
        checkOutput("t33_reachPost", 128'(hit), 128'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        checkOutput("t33_abortBusy", 128'(busy), 128'd0);
        checkOutput("t33_abortValid", 128'(osValid), 128'd0);
        repeat (20) @(negedge clk);
        checkOutput("t33_noFinish", 128'(finishTotal - fbase), 128'd0);
        base = xferTotal;
        applyStimulus(4'd11, 8'h05, 8'h00, 1'b0, 5'd4);
        waitFinish("t33_restart", 20, 1'b1);
        checkOutput("t33_restartXfers", 128'(xferTotal - base), 128'd1);

        // abort wins over start in IDLE
        @(negedge clk);
        abort = 1'b1; start = 1'b1; substate = 4'd11;
        @(negedge clk);
        abort = 1'b0; start = 1'b0;
        checkOutput("abortPrio_busy", 128'(busy), 128'd0);

        // Unsupported substate: finish without osValid
        base = xferTotal;
        vbase = validTotal;
        applyStimulus(4'd0, 8'h00, 8'h00, 1'b0, 5'd4);
        waitFinish("t34", 1, 1'b0);
        checkOutput("t34_xfers", 128'(xferTotal - base), 128'd0);
        checkOutput("t34_noValid", 128'(validTotal - vbase), 128'd0);

        // ConfigIdle: all-zero ordered sets, 1 + 16 transfers
        base = xferTotal;
        applyStimulus(4'd9, 8'hFF, 8'hFF, 1'b1, 5'd3);
        checkOutput("idle_laneEnable", 128'(laneEnable), 128'h0007);
        checkOutput("idle_osAny", 128'(|orderedSets), 128'd0);
        waitFinish("idle", 40, 1'b1);
        checkOutput("idle_xfers", 128'(xferTotal - base), 128'd17);

        // Reset mid-job stays in IDLE afterwards
        applyStimulus(4'd2, 8'h01, 8'h00, 1'b0, 5'd4);
        repeat (10) @(negedge clk);
        reset = 1'b0;
        #2;
        checkOutput("rstMid_busy", 128'(busy), 128'd0);
        checkOutput("rstMid_laneEnable", 128'(laneEnable), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("rstMid_stayIdle", 128'({busy, osValid}), 128'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
